// File: rtl/pwmencoder_pkg.sv
// pwm_pkg: shared constants, state type and defaults for the PWM encoder/decoder pair
// Ports: none (package)
package pwm_pkg;
  localparam int PWM_ERR_BIT = 15;
  localparam int PWM_US_PER_S = 1_000_000;
  localparam int PWM_FRAME_US = 20000;
  localparam int PWM_MIN_US = 800;
  localparam int PWM_MAX_US = 2500;
  localparam int PWM_DEFAULT_US = 1000;
  typedef enum logic [1:0] {S_HIGH, S_LOW, S_OFF} pwm_state_t;
endpackage

// File: rtl/pwmencoder_if.sv
// pwmencoder_if: command handshake between the register bank and the encoder
// Signals: value[15:0] (bit 15 disable, [14:0] width in us), valid, ready
interface pwmencoder_if;
  logic [15:0] value;
  logic valid;
  logic ready;
  modport master(output value, valid, input ready);
  modport slave(input value, valid, output ready);
endinterface

// File: rtl/pwmencoder_us_tick.sv
// pwm_us_tick: microsecond prescaler, o_tick high on the terminal count of each 1 us window
// Ports: i_clk, i_resetn (async active-low), o_tick
module pwm_us_tick
  import pwm_pkg::*;
#(
  parameter int clockFreq = 50_000_000
) (
  input  logic i_clk,
  input  logic i_resetn,
  output logic o_tick
);
  localparam int DIV = clockFreq / PWM_US_PER_S;
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  logic [W-1:0] cnt;
  assign o_tick = cnt == W'(DIV - 1);
  always_ff @(posedge i_clk or negedge i_resetn)
    if (!i_resetn) cnt <= '0;
    else cnt <= o_tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/pwmencoder.sv
// pwmencoder: fixed-period servo/ESC PWM generator with frame-aligned double-buffered width updates
// Ports: i_clk, i_resetn (async active-low), cmd (pwmencoder_if.slave: value/valid/ready),
//        o_pwm (registered PWM output), o_frame_start (one-cycle pulse at each frame start)
// Build option: PWMENCODER_CLAMP_EN clamps widths to [minUs, maxUs]; otherwise only the
//               frameUs-1 saturation applies. Bit 15 disables the output in both builds.
module pwmencoder
  import pwm_pkg::*;
#(
  parameter int clockFreq = 50_000_000,
  parameter int frameUs = PWM_FRAME_US,
  parameter int minUs = PWM_MIN_US,
  parameter int maxUs = PWM_MAX_US,
  parameter int defaultUs = PWM_DEFAULT_US
) (
  input  logic         i_clk,
  input  logic         i_resetn,
  pwmencoder_if.slave  cmd,
  output logic         o_pwm,
  output logic         o_frame_start
);
  localparam int UW = $clog2(frameUs);
  logic us_tick, boundary, accept, pending, pwm_d;
  logic [UW-1:0] us_cnt;
  logic [15:0] shadow, active, load;
  logic [14:0] w, load_w;
  pwm_state_t state, state_nx;
  function automatic logic [14:0] eff_width(input logic [14:0] raw);
    logic [14:0] c;
`ifdef PWMENCODER_CLAMP_EN
    c = raw < 15'(minUs) ? 15'(minUs) : raw > 15'(maxUs) ? 15'(maxUs) : raw;
`else
    c = raw;
`endif
    // saturating below frameUs guarantees a falling edge in every frame
    return c >= 15'(frameUs) ? 15'(frameUs - 1) : c;
  endfunction
  pwm_us_tick #(.clockFreq(clockFreq)) u_tick (
    .i_clk(i_clk),
    .i_resetn(i_resetn),
    .o_tick(us_tick)
  );
  assign boundary = us_tick && us_cnt == UW'(frameUs - 1);
  assign cmd.ready = !pending;
  assign accept = cmd.valid && !pending;
  // value that becomes active at the boundary: a pending shadow wins, no bypass of a same-cycle accept
  assign load = pending ? shadow : active;
  assign w = eff_width(active[14:0]);
  assign load_w = eff_width(load[14:0]);
  always_comb begin
    state_nx = state;
    if (boundary) state_nx = load[PWM_ERR_BIT] ? S_OFF : (load_w != '0 ? S_HIGH : S_LOW);
    else if (state == S_HIGH && 15'(us_cnt) >= w) state_nx = S_LOW;
    pwm_d = state == S_HIGH && 15'(us_cnt) < w;
  end
  always_ff @(posedge i_clk or negedge i_resetn)
    if (!i_resetn) begin
      us_cnt <= '0;
      shadow <= '0;
      active <= 16'(defaultUs);
      pending <= 1'b0;
      state <= S_HIGH;
      o_pwm <= 1'b0;
      o_frame_start <= 1'b0;
    end else begin
      if (us_tick) us_cnt <= boundary ? '0 : us_cnt + 1'b1;
      if (accept) shadow <= cmd.value;
      if (boundary && pending) active <= shadow;
      pending <= accept || (pending && !boundary);
      state <= state_nx;
      o_pwm <= pwm_d;
      o_frame_start <= boundary;
    end
endmodule

// File: tb/tb_pwmencoder.sv
// tb_pwmencoder: randomized scoreboard bench for pwmencoder with a frame-level reference model
module tb_pwmencoder;
  import pwm_pkg::*;
  localparam int CF = 2_000_000;
  localparam int N = CF / 1_000_000;
  localparam int FU = 400;
  localparam int MINU = 80;
  localparam int MAXU = 250;
  localparam int DEFU = 100;
  localparam int P = FU * N;
  logic i_clk = 1'b0;
  logic i_resetn = 1'b0;
  logic o_pwm, o_frame_start;
  pwmencoder_if bus();
  pwmencoder #(
    .clockFreq(CF), .frameUs(FU), .minUs(MINU), .maxUs(MAXU), .defaultUs(DEFU)
  ) dut (
    .i_clk(i_clk),
    .i_resetn(i_resetn),
    .cmd(bus),
    .o_pwm(o_pwm),
    .o_frame_start(o_frame_start)
  );
  always #5 i_clk = ~i_clk;
  typedef struct {int frame; int width;} exp_t;
  exp_t q[$];
  int tests = 0, fails = 0;
  int edges = 0;
  int busy_from = -1, busy_to = -1, last_f = 0;
  int cur_w = DEFU, hi = 0, bad = 0, c, off, f;
  logic exp_bit;
  always @(posedge i_clk or negedge i_resetn)
    if (!i_resetn) edges <= 0;
    else edges <= edges + 1;
  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, edges);
    end
  endtask
  // pulse width in us the spec's rules give for a command word
  function automatic int model_width(input logic [15:0] v);
    int r;
    if (v[15]) return 0;
    r = int'(v[14:0]);
`ifdef PWMENCODER_CLAMP_EN
    r = r < MINU ? MINU : (r > MAXU ? MAXU : r);
`endif
    return r > FU - 1 ? FU - 1 : r;
  endfunction
  // monitor: per-cycle waveform compared against the model; frame totals scored at each frame start
  always @(negedge i_clk) begin
    if (!i_resetn) begin
      cur_w = DEFU; hi = 0; bad = 0; busy_from = -1; busy_to = -1;
      q.delete();
    end else begin
      c = edges; off = c % P; f = c / P;
      if (o_frame_start || (off == 0 && c > 0)) begin
        check("frame_start_pos", int'(o_frame_start && off == 0 && c > 0), 1);
        if (off == 0) begin
          check($sformatf("high_clocks_f%0d", f - 1), hi, cur_w * N);
          check($sformatf("wave_ready_f%0d", f - 1), bad, 0);
          hi = 0; bad = 0;
          while (q.size() > 0 && q[0].frame <= f) cur_w = q.pop_front().width;
        end
      end
      exp_bit = off >= 1 && off <= cur_w * N;
      if (o_pwm !== exp_bit) bad++;
      if (bus.ready !== !(c >= busy_from && c < busy_to)) bad++;
      hi += int'(o_pwm);
    end
  end
  task automatic idle(input int n);
    repeat (n) @(negedge i_clk);
  endtask
  // called at a negedge; holds valid until ready, then scores the command for its target frame
  task automatic send(input logic [15:0] v);
    int n = 0, e;
    exp_t x;
    bus.value = v;
    bus.valid = 1'b1;
    while (!bus.ready && n < 3 * P) begin
      @(negedge i_clk);
      n++;
    end
    if (!bus.ready) begin
      check("accept_timeout", 0, 1);
      bus.valid = 1'b0;
      return;
    end
    e = edges + 1;
    x.frame = e / P + 1;
    x.width = model_width(v);
    q.push_back(x);
    busy_from = e;
    busy_to = x.frame * P;
    last_f = x.frame;
    @(negedge i_clk);
    bus.valid = 1'b0;
  endtask
  task automatic release_reset();
    @(negedge i_clk);
    #1 i_resetn = 1'b1;
  endtask
  initial begin
    #900_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end
  initial begin
    int n;
    logic [15:0] v;
    bus.value = '0;
    bus.valid = 1'b0;
    idle(3);
    check("rst_pwm", int'(o_pwm), 0);
    check("rst_ready", int'(bus.ready), 1);
    check("rst_frame_start", int'(o_frame_start), 0);
    release_reset();
    idle(2 * P + 300);
    send(16'd150);
    idle(100);
    send(16'd30);
    send(16'd300);
    send(16'd2500);
    send(16'h8000);
    send(16'd120);
    send(16'd0);
    send(16'd110);
    n = 0;
    while (!((edges + 1) % P == 0 && bus.ready) && n < 4 * P) begin
      @(negedge i_clk);
      n++;
    end
    check("boundary_wait", int'((edges + 1) % P == 0 && bus.ready), 1);
    send(16'd170);
    send(16'd200);
    n = 0;
    while (!(edges / P >= last_f && edges % P == 100) && n < 4 * P) begin
      @(negedge i_clk);
      n++;
    end
    check("pwm_high_before_rst", int'(o_pwm), 1);
    #2 i_resetn = 1'b0;
    #1 check("rst_async_pwm_low", int'(o_pwm), 0);
    check("rst_async_ready", int'(bus.ready), 1);
    idle(2);
    release_reset();
    idle(P + 50);
    for (int i = 0; i < 14; i++) begin
      idle($urandom_range(0, 600));
      v = 16'($urandom_range(0, 600));
      if ($urandom_range(0, 5) == 0) v[15] = 1'b1;
      send(v);
    end
    idle(3 * P);
    check("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
